// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback select for the MIPS datapath.
// Drives the register-file write port, suppresses $zero writes and counts retirements.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [4:0]        in_write_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_offset,
  output logic              RegWrite,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              wb_valid,
  output logic              zero_drop,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic              s_valid;
  logic              s_reg_write;
  logic [1:0]        s_wb_sel;
  logic [4:0]        s_write_reg;
  logic [DATA_W-1:0] s_alu;
  logic [DATA_W-1:0] s_mem;
  logic [DATA_W-1:0] s_pc4;
  logic [2:0]        s_load_type;
  logic [1:0]        s_offset;

  logic              retire;
  logic              dest_zero;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [DATA_W-1:0] load_data;

  // Stage register; flush only kills valid, the payload is left as don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid     <= 1'b0;
      s_reg_write <= 1'b0;
      s_wb_sel    <= '0;
      s_write_reg <= '0;
      s_alu       <= '0;
      s_mem       <= '0;
      s_pc4       <= '0;
      s_load_type <= '0;
      s_offset    <= '0;
    end else if (flush) begin
      s_valid <= 1'b0;
    end else if (!stall) begin
      s_valid     <= in_valid;
      s_reg_write <= in_reg_write;
      s_wb_sel    <= in_wb_sel;
      s_write_reg <= in_write_reg;
      s_alu       <= in_alu_result;
      s_mem       <= in_mem_data;
      s_pc4       <= in_pc_plus4;
      s_load_type <= in_load_type;
      s_offset    <= in_byte_offset;
    end
  end

  assign retire    = s_valid & ~stall;
  assign dest_zero = (s_write_reg == 5'd0);

  // Suppressed $zero writes still retire and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + 1'b1;
    end
  end

  // Big-endian lane select: offset 0 addresses the most significant byte.
  always_comb begin
    load_byte = s_mem[31:24];
    case (s_offset)
      2'd0: load_byte = s_mem[31:24];
      2'd1: load_byte = s_mem[23:16];
      2'd2: load_byte = s_mem[15:8];
      2'd3: load_byte = s_mem[7:0];
      default: load_byte = s_mem[31:24];
    endcase
  end

  assign load_half = s_offset[1] ? s_mem[15:0] : s_mem[31:16];

  always_comb begin
    load_data = s_mem;
    case (s_load_type)
      LT_LW:   load_data = s_mem;
      LT_LB:   load_data = {{(DATA_W-8){load_byte[7]}}, load_byte};
      LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, load_byte};
      LT_LH:   load_data = {{(DATA_W-16){load_half[15]}}, load_half};
      LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, load_half};
      default: load_data = s_mem;
    endcase
  end

  always_comb begin
    write_data = s_alu;
    case (s_wb_sel)
      SEL_ALU:  write_data = s_alu;
      SEL_LOAD: write_data = load_data;
      SEL_LINK: write_data = s_pc4;
      default:  write_data = s_alu;
    endcase
  end

  assign RegWrite  = retire & s_reg_write & ~dest_zero;
  assign zero_drop = retire & s_reg_write & dest_zero;
  assign write_reg = s_write_reg;
  assign wb_valid  = s_valid;

endmodule
